usb_rst_sequencer: RTL and testbench

USB_RST_SEQUENCER -- requirements
Module: usb_rst_sequencer

---
 rtl/usb_rst_pkg.sv | 26 ++
 rtl/usb_rst_downcnt.sv | 42 ++++
 rtl/usb_rst_sequencer.sv | 179 +++++++++++++++++
 tb/tb_usb_rst_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rst_pkg.sv
// Shared definitions for the USB OTG reset sequencer.
//   - state_e      : sequencer states, encoded as they appear in the CTRL read
//   - ADDR_*       : Avalon-MM register addresses
//   - CNT_W        : width of the delay counter and both config registers
//   - cfg_sanitize : maps a written value of 0 to 1 so a delay is never empty
package usb_rst_pkg;

    localparam int CNT_W = 20;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_ASSERT = 2'd1;
    localparam logic [1:0] ADDR_WAIT   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_READY  = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] cfg_sanitize(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/usb_rst_downcnt.sv
// Loadable down-counter that saturates at zero.
// Ports:
//   clk      : clock
//   srst     : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, holding at zero
//   zero     : high while the count is zero
module usb_rst_downcnt
    import usb_rst_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/usb_rst_sequencer.sv
// USB OTG controller reset sequencer with an Avalon-MM register file.
// A reset request (PIO level or software strobe) holds otg_rst_n low for
// assert_cfg cycles (longer while the request persists), then waits
// wait_cfg cycles before reporting ready and pulsing done_pulse.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   rst_req               : level reset request from the PIO
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side
//   readdata              : Avalon-MM read data, combinational from address
//   otg_rst_n             : registered active-low reset to the OTG controller
//   ready                 : registered, controller out of reset and settled
//   done_pulse            : registered one-cycle strobe on entry to READY
module usb_rst_sequencer
    import usb_rst_pkg::*;
#(
    parameter int unsigned ASSERT_DEFAULT = 5000,
    parameter int unsigned WAIT_DEFAULT   = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rst_req,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        otg_rst_n,
    output logic        ready,
    output logic        done_pulse
);

    localparam logic [CNT_W-1:0] ASSERT_INIT = CNT_W'(ASSERT_DEFAULT);
    localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'(WAIT_DEFAULT);

    state_e           state_q, state_d;
    logic             otg_rst_n_q, otg_rst_n_d;
    logic             ready_q, ready_d;
    logic             done_pulse_q, done_pulse_d;
    logic [15:0]      reset_count_q, reset_count_d;
    logic [CNT_W-1:0] assert_cfg_q, assert_cfg_d;
    logic [CNT_W-1:0] wait_cfg_q, wait_cfg_d;

    logic             wr_en;
    logic             sw_req;
    logic             req;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             count_inc;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:CNT_W];

    assign wr_en  = chipselect && !write_n;
    assign sw_req = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign req    = rst_req || sw_req;

    // The counter is loaded with cfg-1 and the state moves on the edge where
    // it reads zero, so the phase lasts exactly cfg cycles from the load edge.
    usb_rst_downcnt u_downcnt (
        .clk      (clk),
        .srst     (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer next-state logic
    always_comb begin
        state_d      = state_q;
        otg_rst_n_d  = otg_rst_n_q;
        ready_d      = ready_q;
        done_pulse_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = assert_cfg_q - CNT_W'(1);
        cnt_dec      = 1'b0;
        count_inc    = 1'b0;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (req) begin
                    state_d     = ST_ASSERT;
                    otg_rst_n_d = 1'b0;
                    ready_d     = 1'b0;
                    cnt_load    = 1'b1;
                end
            end
            ST_ASSERT: begin
                // A held request keeps the controller in reset past the timer.
                if (cnt_zero && !req) begin
                    state_d      = ST_WAIT;
                    otg_rst_n_d  = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = wait_cfg_q - CNT_W'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                if (req) begin
                    state_d     = ST_ASSERT;
                    otg_rst_n_d = 1'b0;
                    cnt_load    = 1'b1;
                end else if (cnt_zero) begin
                    state_d      = ST_READY;
                    ready_d      = 1'b1;
                    done_pulse_d = 1'b1;
                    count_inc    = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register file next-state logic
    always_comb begin
        assert_cfg_d  = assert_cfg_q;
        wait_cfg_d    = wait_cfg_q;
        reset_count_d = reset_count_q;

        if (wr_en && (address == ADDR_ASSERT)) begin
            assert_cfg_d = cfg_sanitize(writedata[CNT_W-1:0]);
        end
        if (wr_en && (address == ADDR_WAIT)) begin
            wait_cfg_d = cfg_sanitize(writedata[CNT_W-1:0]);
        end

        // Clear wins over a coincident increment.
        if (wr_en && (address == ADDR_COUNT)) begin
            reset_count_d = '0;
        end else if (count_inc && (reset_count_q != 16'hFFFF)) begin
            reset_count_d = reset_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            otg_rst_n_q   <= 1'b1;
            ready_q       <= 1'b0;
            done_pulse_q  <= 1'b0;
            reset_count_q <= '0;
            assert_cfg_q  <= ASSERT_INIT;
            wait_cfg_q    <= WAIT_INIT;
        end else begin
            state_q       <= state_d;
            otg_rst_n_q   <= otg_rst_n_d;
            ready_q       <= ready_d;
            done_pulse_q  <= done_pulse_d;
            reset_count_q <= reset_count_d;
            assert_cfg_q  <= assert_cfg_d;
            wait_cfg_q    <= wait_cfg_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {28'b0, otg_rst_n_q, state_q, ready_q};
            ADDR_ASSERT: readdata = {{(32-CNT_W){1'b0}}, assert_cfg_q};
            ADDR_WAIT:   readdata = {{(32-CNT_W){1'b0}}, wait_cfg_q};
            ADDR_COUNT:  readdata = {16'b0, reset_count_q};
            default:     readdata = '0;
        endcase
    end

    assign otg_rst_n  = otg_rst_n_q;
    assign ready      = ready_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed self-checking bench for usb_rst_sequencer.
module tb_usb_rst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst_req;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        otg_rst_n;
    logic        ready;
    logic        done_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    usb_rst_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .rst_req    (rst_req),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .otg_rst_n  (otg_rst_n),
        .ready      (ready),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Cycles otg_rst_n stays low, counted from the current sample.
    task automatic measure_low(output int n);
        n = 0;
        while (otg_rst_n === 1'b0 && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Cycles until ready rises, counted from the current sample.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_req();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;

        reset = 1'b1; rst_req = 1'b0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_otg", 32'(otg_rst_n), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        rd(2'd0, d); chk("rst_ctrl", d, 32'h8);
        rd(2'd1, d); chk("rst_acfg", d, 32'd5000);
        rd(2'd2, d); chk("rst_wcfg", d, 32'd500000);
        rd(2'd3, d); chk("rst_count", d, 32'd0);
        reset = 1'b0;

        // One-cycle request, assert 4 / wait 3
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd3);
        rd(2'd1, d); chk("acfg_4", d, 32'd4);
        rd(2'd2, d); chk("wcfg_3", d, 32'd3);
        pulse_req();
        chk("seq1_otg0", 32'(otg_rst_n), 32'd0);
        rd(2'd0, d); chk("seq1_ctrl_as", d, 32'h2);
        measure_low(n); chk("seq1_low", 32'(n), 32'd4);
        rd(2'd0, d); chk("seq1_ctrl_wt", d, 32'hC);
        wait_ready(n); chk("seq1_wait", 32'(n), 32'd3);
        chk("seq1_done1", 32'(done_pulse), 32'd1);
        rd(2'd0, d); chk("seq1_ctrl_rd", d, 32'hF);
        tick();
        chk("seq1_done0", 32'(done_pulse), 32'd0);
        rd(2'd3, d); chk("seq1_count", d, 32'd1);

        // Request held 10 cycles
        rst_req = 1'b1;
        tick();
        chk("held_ready0", 32'(ready), 32'd0);
        repeat (9) tick();
        rst_req = 1'b0;
        measure_low(n); chk("held_low", 32'(n + 9), 32'd10);
        rd(2'd0, d); chk("held_ctrl_wt", d, 32'hC);
        wait_ready(n); chk("held_wait", 32'(n), 32'd3);
        rd(2'd3, d); chk("held_count", d, 32'd2);

        // Request again in the second WAIT cycle restarts the sequence
        pulse_req();
        measure_low(n); chk("rst_low_a", 32'(n), 32'd4);
        tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        chk("rst_otg0", 32'(otg_rst_n), 32'd0);
        chk("rst_ready0", 32'(ready), 32'd0);
        measure_low(n); chk("rst_low_b", 32'(n), 32'd4);
        wait_ready(n); chk("rst_wait", 32'(n), 32'd3);
        rd(2'd3, d); chk("rst_count3", d, 32'd3);

        // Zero config stored as 1; software request via addr0
        wr(2'd1, 32'd0);
        rd(2'd1, d); chk("acfg_zero", d, 32'd1);
        wr(2'd0, 32'h1);
        chk("sw_otg0", 32'(otg_rst_n), 32'd0);
        measure_low(n); chk("sw_low", 32'(n), 32'd1);
        wait_ready(n); chk("sw_wait", 32'(n), 32'd3);
        rd(2'd3, d); chk("sw_count", d, 32'd4);
        wr(2'd0, 32'h2);
        chk("sw_bit1_otg", 32'(otg_rst_n), 32'd1);
        chk("sw_bit1_rdy", 32'(ready), 32'd1);

        // Counter saturation and clearing
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        force dut.reset_count_q = 16'hFFFE;
        tick();
        release dut.reset_count_q;
        rd(2'd3, d); chk("sat_preload", d, 32'hFFFE);
        pulse_req();
        measure_low(n); chk("sat_low", 32'(n), 32'd1);
        wait_ready(n); chk("sat_wait", 32'(n), 32'd1);
        chk("sat_done", 32'(done_pulse), 32'd1);
        rd(2'd3, d); chk("sat_ffff", d, 32'hFFFF);
        pulse_req();
        measure_low(n);
        wait_ready(n);
        rd(2'd3, d); chk("sat_hold", d, 32'hFFFF);
        wr(2'd3, 32'd123);
        rd(2'd3, d); chk("clr_count", d, 32'd0);

        // Clear on the same edge as the increment leaves zero
        pulse_req();
        tick();
        wr(2'd3, 32'd0);
        chk("coinc_ready", 32'(ready), 32'd1);
        chk("coinc_done", 32'(done_pulse), 32'd1);
        rd(2'd3, d); chk("coinc_count", d, 32'd0);

        // Reset mid-ASSERT aborts the sequence
        wr(2'd1, 32'd4);
        pulse_req();
        tick();
        chk("mid_otg0", 32'(otg_rst_n), 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_otg1", 32'(otg_rst_n), 32'd1);
        chk("mid_ready", 32'(ready), 32'd0);
        rd(2'd0, d); chk("mid_ctrl", d, 32'h8);
        rd(2'd1, d); chk("mid_acfg", d, 32'd5000);
        rd(2'd2, d); chk("mid_wcfg", d, 32'd500000);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
